// File: rtl/sobel_hls_mul_pipe.sv
// rtl/sobel_hls_mul_pipe.sv - pipelined valid/ready integer multiplier for the Sobel datapath
// Define SOBEL_MUL_SAT_EN to clamp out-of-range results and flag them on ovf.
module sobel_hls_mul_pipe #(
    parameter int din0_WIDTH  = 14,
    parameter int din1_WIDTH  = 12,
    parameter int dout_WIDTH  = 26,
    parameter int NUM_STAGE   = 3,
    parameter int din0_SIGNED = 0,
    parameter int din1_SIGNED = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int P = din0_WIDTH + din1_WIDTH + 1;
`ifdef SOBEL_MUL_SAT_EN
    localparam int XW = ((P > dout_WIDTH) ? P : dout_WIDTH) + 2;
    localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] SMAX = (ONE << (dout_WIDTH - 1)) - ONE;
    localparam logic signed [XW-1:0] SMIN = ~SMAX;
    localparam logic signed [XW-1:0] UMAX = (ONE << dout_WIDTH) - ONE;
`endif

    // Returns {ovf, dout}; P bits always hold the exact product, so no precision is lost here.
    function automatic logic [dout_WIDTH:0] shape(input logic signed [P-1:0] prod);
`ifdef SOBEL_MUL_SAT_EN
        logic signed [XW-1:0] px;
        px = XW'(prod);
        if (RES_SIGNED && (px > SMAX)) return {1'b1, SMAX[dout_WIDTH-1:0]};
        if (RES_SIGNED && (px < SMIN)) return {1'b1, SMIN[dout_WIDTH-1:0]};
        if (!RES_SIGNED && (px > UMAX)) return {1'b1, UMAX[dout_WIDTH-1:0]};
`endif
        return {1'b0, dout_WIDTH'(prod)};
    endfunction

    logic signed [P-1:0] ext0;
    logic signed [P-1:0] ext1;

    always_comb begin
        ext0 = {{(P - din0_WIDTH){(din0_SIGNED != 0) && din0[din0_WIDTH-1]}}, din0};
        ext1 = {{(P - din1_WIDTH){(din1_SIGNED != 0) && din1[din1_WIDTH-1]}}, din1};
    end

    if (NUM_STAGE == 0) begin : g_comb
        logic signed [P-1:0] prod;
        assign prod        = ext0 * ext1;
        assign in_ready    = out_ready;
        assign out_valid   = in_valid;
        assign {ovf, dout} = shape(prod);
    end else begin : g_pipe
        logic [NUM_STAGE:1]   vld_q;
        logic [NUM_STAGE:1]   vld_d;
        logic [NUM_STAGE+1:1] ld;
        logic [NUM_STAGE:0]   vin;
        logic [dout_WIDTH:0]  res_q;
        logic [dout_WIDTH:0]  res_d;
        logic [dout_WIDTH:0]  res_in;

        // A stage loads when empty or when its successor loads, so bubbles collapse toward the tail.
        always_comb begin
            vin             = {vld_q, in_valid};
            ld              = '0;
            ld[NUM_STAGE+1] = out_ready;
            for (int k = NUM_STAGE; k >= 1; k--) begin
                ld[k] = !vld_q[k] || ld[k+1];
            end
            for (int k = 1; k <= NUM_STAGE; k++) begin
                vld_d[k] = ld[k] ? vin[k-1] : vld_q[k];
            end
            res_d = ld[NUM_STAGE] ? res_in : res_q;
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                vld_q <= '0;
                res_q <= '0;
            end else begin
                vld_q <= vld_d;
                res_q <= res_d;
            end
        end

        assign in_ready    = ld[1];
        assign out_valid   = vld_q[NUM_STAGE];
        assign {ovf, dout} = res_q;

        if (NUM_STAGE == 1) begin : g_one
            logic signed [P-1:0] prod;
            assign prod   = ext0 * ext1;
            assign res_in = shape(prod);
        end else begin : g_multi
            logic signed [P-1:0] op0_q;
            logic signed [P-1:0] op0_d;
            logic signed [P-1:0] op1_q;
            logic signed [P-1:0] op1_d;
            logic signed [P-1:0] prod;

            always_comb begin
                op0_d = ld[1] ? ext0 : op0_q;
                op1_d = ld[1] ? ext1 : op1_q;
            end

            always_ff @(posedge ap_clk) begin
                op0_q <= op0_d;
                op1_q <= op1_d;
            end

            assign prod = op0_q * op1_q;

            if (NUM_STAGE == 2) begin : g_two
                assign res_in = shape(prod);
            end else begin : g_delay
                logic signed [P-1:0] mid_q [2:NUM_STAGE-1];
                logic signed [P-1:0] mid_d [2:NUM_STAGE-1];

                always_comb begin
                    mid_d[2] = ld[2] ? prod : mid_q[2];
                    for (int k = 3; k <= NUM_STAGE - 1; k++) begin
                        mid_d[k] = ld[k] ? mid_q[k-1] : mid_q[k];
                    end
                end

                always_ff @(posedge ap_clk) begin
                    mid_q <= mid_d;
                end

                assign res_in = shape(mid_q[NUM_STAGE-1]);
            end
        end
    end
endmodule
